// File: rtl/pipeline_fetch_unit.sv
// Instruction fetch stage: fetch PC, imem req/ack handshake,
// small prefetch FIFO feeding the IF/ID register.
module pipeline_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch,
  input  logic [31:0] branchTarget,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemAck,
  input  logic [31:0] imemData,
  output logic [31:0] pcPlus4,
  output logic [31:0] preInstruction,
  output logic        ifIdWrIn,
  output logic        fetchValid
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    FULL   = 2'd1,
    SQUASH = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            live_q;
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     sq_q, sq_d;
  logic [PW-1:0]   wr_q, wr_d;
  logic [PW-1:0]   rd_q, rd_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   cnt_after;
  logic [31:0]     pc4_mem   [DEPTH];
  logic [31:0]     instr_mem [DEPTH];
  logic            push, pop, fire, empty;
  logic [31:0]     pc_inc;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty     = (cnt_q == '0);
  assign fire      = imemReq & imemAck;
  assign pop       = ~stall & ~empty & ~branch;
  assign pc_inc    = pc_q + 32'd4;
  assign cnt_after = pop ? cnt_q : cnt_q + CW'(1);

  // live_q keeps the request low until the first edge after reset
  assign imemReq        = live_q & (state_q != FULL);
  assign imemAddr       = (state_q == SQUASH) ? sq_q : pc_q;
  assign pcPlus4        = empty ? '0 : pc4_mem[rd_q];
  assign preInstruction = empty ? '0 : instr_mem[rd_q];
  assign ifIdWrIn       = ~stall;
  assign fetchValid     = ~empty;

  // next state, fetch PC and push decision; branch overrides all
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    sq_d    = sq_q;
    push    = 1'b0;
    if (branch) begin
      pc_d = branchTarget & ~32'h3;
      if (state_q == SQUASH) begin
        state_d = fire ? FETCH : SQUASH;
      end else if ((state_q == FETCH) && imemReq && !imemAck) begin
        state_d = SQUASH;
        sq_d    = pc_q;
      end else begin
        state_d = FETCH;
      end
    end else begin
      unique case (state_q)
        FETCH: begin
          if (fire) begin
            push = 1'b1;
            pc_d = pc_inc;
            if (cnt_after == CW'(DEPTH)) state_d = FULL;
          end
        end
        FULL:    if (pop) state_d = FETCH;
        SQUASH:  if (fire) state_d = FETCH;
        default: state_d = FETCH;
      endcase
    end
  end

  // FIFO pointers and occupancy
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (branch) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) wr_d = nxt(wr_q);
      if (pop)  rd_d = nxt(rd_q);
      if (push && !pop)      cnt_d = cnt_q + CW'(1);
      else if (!push && pop) cnt_d = cnt_q - CW'(1);
    end
  end

  // control state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH;
      live_q  <= 1'b0;
      pc_q    <= RESET_PC;
      sq_q    <= RESET_PC;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
      pc_q    <= pc_d;
      sq_q    <= sq_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
    end
  end

  // FIFO storage; validity is tracked by cnt_q
  always_ff @(posedge clk) begin
    if (push) begin
      pc4_mem[wr_q]   <= pc_inc;
      instr_mem[wr_q] <= imemData;
    end
  end

endmodule

// File: tb/tb_pipeline_fetch_unit.sv
// Bench for pipeline_fetch_unit: latency-programmable memory,
// scoreboard of the expected instruction stream.
module tb_pipeline_fetch_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branch;
  logic [31:0] branchTarget;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemAck;
  logic [31:0] imemData;
  logic [31:0] pcPlus4;
  logic [31:0] preInstruction;
  logic        ifIdWrIn;
  logic        fetchValid;

  logic [3:0]  lat;
  logic [3:0]  wcnt;
  logic [63:0] sbq[$];
  int          n_chk;
  int          n_pass;
  int          n_cons;

  pipeline_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .branch         (branch),
    .branchTarget   (branchTarget),
    .imemReq        (imemReq),
    .imemAddr       (imemAddr),
    .imemAck        (imemAck),
    .imemData       (imemData),
    .pcPlus4        (pcPlus4),
    .preInstruction (preInstruction),
    .ifIdWrIn       (ifIdWrIn),
    .fetchValid     (fetchValid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory: ack in the lat-th cycle of a request, data = addr|A0000000
  always @(posedge clk or negedge reset) begin
    if (!reset)                     wcnt <= '0;
    else if (imemReq && !imemAck)   wcnt <= wcnt + 4'd1;
    else                            wcnt <= '0;
  end
  assign imemAck  = imemReq && (wcnt == lat - 4'd1);
  assign imemData = imemAddr | 32'hA000_0000;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic sb_seq(input logic [31:0] start);
    logic [31:0] a;
    sbq.delete();
    a = start;
    for (int i = 0; i < 40; i++) begin
      sbq.push_back({a + 32'd4, a | 32'hA000_0000});
      a = a + 32'd4;
    end
  endtask

  task automatic do_branch(input logic [31:0] t);
    branch       = 1'b1;
    branchTarget = t;
    sb_seq(t);
  endtask

  task automatic do_reset(input logic [3:0] l);
    reset        = 1'b0;
    stall        = 1'b0;
    branch       = 1'b0;
    branchTarget = '0;
    lat          = l;
    sb_seq(32'h0);
    repeat (2) cyc();
    reset = 1'b1;
  endtask

  task automatic wait_valid(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      cyc();
      ok = fetchValid;
    end
    if (!ok) chk(tag, 0, 1);
  endtask

  // consumed heads must follow the expected stream
  always @(negedge clk) begin
    if (reset && fetchValid && !stall && !branch) begin
      if (sbq.size() == 0) begin
        chk("sb_extra", 1, 0);
      end else begin
        chk("sb_head", {pcPlus4, preInstruction}, sbq.pop_front());
        n_cons++;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog got=hang exp=finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    int n0;
    n_chk  = 0;
    n_pass = 0;
    n_cons = 0;
    reset        = 1'b0;
    stall        = 1'b0;
    branch       = 1'b0;
    branchTarget = '0;
    lat          = 4'd1;
    sb_seq(32'h0);

    // reset state, zero-wait streaming
    cyc();
    smp();
    chk("rst_req",   imemReq, 0);
    chk("rst_valid", fetchValid, 0);
    chk("rst_pc4",   pcPlus4, 0);
    chk("rst_instr", preInstruction, 0);
    chk("rst_ifid",  ifIdWrIn, 1);
    cyc();
    reset = 1'b1;
    cyc();
    smp();
    chk("first_req",  imemReq, 1);
    chk("first_addr", imemAddr, 32'h0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      smp();
      chk("zw_instr", preInstruction, 32'hA000_0000 + 32'(4 * i));
      chk("zw_pc4",   pcPlus4, 32'(4 * i + 4));
    end
    cyc();
    n0 = n_cons;
    repeat (10) cyc();
    chk("nobubble", 64'(n_cons - n0), 10);

    // stall 3 cycles with 2-cycle memory
    do_reset(4'd2);
    wait_valid("to_stall_valid");
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      smp();
      chk("stall_ifid", ifIdWrIn, 0);
      chk("stall_head", preInstruction, 32'hA000_0000);
      if (i == 2) begin
        chk("full_req",   imemReq, 0);
        chk("full_valid", fetchValid, 1);
      end
      cyc();
    end
    stall = 1'b0;
    smp();
    cyc();
    smp();
    chk("resume_req",  imemReq, 1);
    chk("resume_addr", imemAddr, 32'h8);
    chk("resume_head", preInstruction, 32'hA000_0004);
    repeat (12) cyc();

    // branch with an outstanding request to 0x8
    do_reset(4'd3);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      cyc();
      ok = imemReq && !imemAck && (imemAddr == 32'h8);
    end
    if (!ok) chk("to_req8", 0, 1);
    do_branch(32'h0000_0100);
    cyc();
    branch = 1'b0;
    smp();
    chk("sq_addr",  imemAddr, 32'h8);
    chk("sq_valid", fetchValid, 0);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      cyc();
      ok = (imemAddr != 32'h8);
    end
    chk("br_addr",  imemAddr, 32'h100);
    chk("br_valid", fetchValid, 0);
    wait_valid("to_br_valid");
    chk("br_pc4", pcPlus4, 32'h104);
    repeat (8) cyc();

    // branch with same-cycle ack, then branch with stall
    do_reset(4'd2);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      cyc();
      ok = (n_cons >= 1) && imemAck;
    end
    if (!ok) chk("to_ack", 0, 1);
    do_branch(32'h0000_0200);
    cyc();
    branch = 1'b0;
    smp();
    chk("ba_valid", fetchValid, 0);
    chk("ba_req",   imemReq, 1);
    chk("ba_addr",  imemAddr, 32'h200);
    wait_valid("to_ba_valid");
    chk("ba_pc4", pcPlus4, 32'h204);
    do_branch(32'h0000_0300);
    stall = 1'b1;
    smp();
    chk("bs_ifid", ifIdWrIn, 0);
    cyc();
    branch = 1'b0;
    stall  = 1'b0;
    smp();
    chk("bs_valid", fetchValid, 0);
    wait_valid("to_bs_valid");
    chk("bs_pc4", pcPlus4, 32'h304);
    repeat (8) cyc();

    // two branches back-to-back while squashing
    do_reset(4'd3);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      cyc();
      ok = imemReq && !imemAck && (imemAddr == 32'h4);
    end
    if (!ok) chk("to_req4", 0, 1);
    do_branch(32'h0000_0040);
    cyc();
    do_branch(32'h0000_0080);
    cyc();
    branch = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      ok = (imemAddr != 32'h4);
      if (!ok) cyc();
    end
    chk("bb_addr", imemAddr, 32'h80);
    wait_valid("to_bb_valid");
    chk("bb_pc4", pcPlus4, 32'h84);
    repeat (10) cyc();

    // asynchronous reset with a full FIFO
    do_reset(4'd2);
    stall = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      cyc();
      ok = !imemReq && fetchValid;
    end
    if (!ok) chk("to_full", 0, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_valid", fetchValid, 0);
    chk("ar_pc4",   pcPlus4, 0);
    chk("ar_instr", preInstruction, 0);
    chk("ar_req",   imemReq, 0);
    sb_seq(32'h0);
    cyc();
    cyc();
    reset = 1'b1;
    stall = 1'b0;
    cyc();
    smp();
    chk("ar_first_req",  imemReq, 1);
    chk("ar_first_addr", imemAddr, 32'h0);
    wait_valid("to_ar_valid");
    chk("ar_pc4_first", pcPlus4, 32'h4);
    repeat (10) cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
